spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Parametrised SPI master: configurable word width, SCLK divider and chip-select count.
- Mode (CPOL/CPHA) and bit order are selectable per transfer.
- Full-duplex: shifts tx_data out on MOSI while capturing MISO into rx_data.
- Sits between an on-chip requester (valid/ready command port) and external SPI slaves.

Parameters:
- DATA_W, 8, bits per transfer; legal values >= 2.
- CLK_DIV, 4, clk cycles per SCLK half-period; legal values >= 2.
- NUM_CS, 1, number of chip-select outputs.
- CS_W, (NUM_CS>1 ? $clog2(NUM_CS) : 1), derived width of cs_sel; not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tx_valid  in  1  transfer request.
- tx_ready  out  1  block idle and able to accept a request.
- tx_data  in  DATA_W  word to transmit.
- cs_sel  in  CS_W  index of the chip select to assert.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- msb_first  in  1  1 = MSB first; 0 = LSB first.
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- rx_data  out  DATA_W  received word, held until the next rx_valid.
- busy  out  1  high whenever not IDLE.
- sclk  out  1  SPI clock, registered.
- cs_n  out  NUM_CS  active-low chip selects, registered.
- mosi  out  1  serial data out, registered.
- miso  in  1  serial data in.

Behaviour:
- Reset (and any rst mid-transfer), outputs in the following cycle:
  - state IDLE, tx_ready=1, busy=0, rx_valid=0, rx_data=0.
  - cs_n all ones, sclk=0, mosi=0.
  - No rx_valid is generated for an aborted transfer.
- Accept: on a clk edge with tx_valid && tx_ready, latch tx_data, cs_sel, cpol, cpha and msb_first.
  - The mode inputs are ignored at all other times.
  - tx_ready drops in the next cycle.
- States: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE:
  - tx_ready=1, busy=0, cs_n all high.
  - sclk equals the cpol latched by the previous transfer (0 after reset); mosi=0.
- SETUP (CLK_DIV cycles):
  - cs_n[cs_sel] low, sclk=cpol.
  - cpha=0: mosi = first bit from entry.
  - cpha=1: mosi=0.
- XFER:
  - 2*DATA_W SCLK edges, one every CLK_DIV cycles. Edge 1 occurs CLK_DIV cycles after cs_n falls.
  - Odd-numbered edges are leading; even-numbered edges are trailing. The last edge returns sclk to cpol.
  - cpha=0: capture miso on leading edges; drive the next bit on trailing edges 2..2*DATA_W-2. No shift on the final edge.
  - cpha=1: drive a bit on each leading edge; capture on each trailing edge.
  - Capture timing: miso is sampled on the same clk edge at which the registered sclk changes to the sampling level.
- Bit order:
  - msb_first=1: bits sent as tx_data[DATA_W-1]..[0]; received bits shift in at the LSB.
  - msb_first=0: bits sent as [0]..[DATA_W-1]; received bits fill from the MSB downward so that rx_data[0] holds the first bit received.
- HOLD (CLK_DIV cycles): cs_n stays low, sclk=cpol, mosi holds the last bit.
- End of transfer: on the cycle cs_n rises, state returns to IDLE, rx_valid=1 for exactly one cycle, and rx_data is updated.
- Timing:
  - cs_n falls 1 cycle after acceptance.
  - cs_n stays low for (2*DATA_W+1)*CLK_DIV cycles; 68 cycles for the default parameters.
  - Acceptance to rx_valid: (2*DATA_W+1)*CLK_DIV+1 cycles.
- Back-to-back: a request presented during the rx_valid cycle is accepted that cycle. cs_n is therefore high for exactly 1 cycle between transfers.
- cs_sel >= NUM_CS: the transfer runs with full timing but no cs_n asserts; rx_valid still pulses.
- tx_valid while busy is ignored; there is no queueing.
- No combinational path from any input to any output.

Test Plan:
- Mode 0, msb_first=1, tx_data=8'hA3, miso looped from mosi:
  - mosi bit sequence 1,0,1,0,0,0,1,1.
  - 16 sclk edges at 4-cycle spacing; cs_n low for 68 cycles.
  - rx_valid at cycle 69 after acceptance with rx_data=8'hA3.
- Mode 3 (cpol=1, cpha=1), tx_data=8'h5C, miso driven with 8'h96 per the mode-3 timing:
  - sclk idles high; 16 edges.
  - rx_data=8'h96; mosi bits change only on falling edges.
- Mode 1, msb_first=0, tx_data=8'h01, miso looped:
  - mosi=1 on the first bit only; rx_data=8'h01.
- NUM_CS=4, two back-to-back requests on cs_sel=2 then cs_sel=3:
  - cs_n[2] low for the first transfer, then all cs_n high for 1 cycle, then cs_n[3] low for the second.
  - Two rx_valid pulses 69 cycles apart.
- rst asserted at cycle 30 of a transfer:
  - Next cycle: cs_n all high, sclk=0, mosi=0, tx_ready=1.
  - No rx_valid follows.
  - A new request is accepted immediately after.
- DATA_W=16, CLK_DIV=2, tx_data=16'hBEEF, miso looped:
  - 32 sclk edges; cs_n low for 66 cycles; rx_data=16'hBEEF.
  - tx_valid pulsed while busy is ignored.

Source files
------------

// File: rtl/spi_master.sv
// rtl/spi_master.sv - parametrised full-duplex SPI master with per-transfer mode and bit order
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 1,
  parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              msb_first,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [DATA_W-1:0]   tx_shift;
  logic [DATA_W-1:0]   rx_shift;
  logic                cpha_q;
  logic                msb_q;

  logic [DATA_W-1:0]   tx_rev;
  logic [DATA_W-1:0]   tx_load;
  logic [EDGE_W-1:0]   edge_num;
  logic                div_done;
  logic                lead;
  logic                sclk_edge;
  logic                do_drive;
  logic                do_cap;

  // Word is always shifted out from the MSB, so LSB-first requests are loaded bit-reversed
  always_comb begin
    tx_rev = '0;
    for (int i = 0; i < DATA_W; i++) begin
      tx_rev[i] = tx_data[DATA_W-1-i];
    end
    tx_load = msb_first ? tx_data : tx_rev;
  end

  // Edge scheduling: one SCLK edge per divider period during SETUP/XFER; odd edges are leading
  always_comb begin
    edge_num  = edge_cnt + 1'b1;
    lead      = edge_num[0];
    div_done  = (div_cnt == DIV_LAST);
    sclk_edge = div_done && ((state == SETUP) || (state == XFER));
    do_drive  = sclk_edge && (cpha_q ? lead : (!lead && (edge_num != EDGE_LAST)));
    do_cap    = sclk_edge && (cpha_q ? !lead : lead);
  end

  // Transfer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      cs_n     <= '1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      cpha_q   <= 1'b0;
      msb_q    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE) begin
        div_cnt <= div_done ? '0 : div_cnt + 1'b1;
      end
      if (sclk_edge) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_num;
      end
      if (do_drive) begin
        mosi     <= tx_shift[DATA_W-1];
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
      if (do_cap) begin
        rx_shift <= msb_q ? {rx_shift[DATA_W-2:0], miso} : {miso, rx_shift[DATA_W-1:1]};
      end
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state    <= SETUP;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            edge_cnt <= '0;
            cpha_q   <= cpha;
            msb_q    <= msb_first;
            sclk     <= cpol;
            for (int i = 0; i < NUM_CS; i++) begin
              cs_n[i] <= (cs_sel != CS_W'(i));
            end
            if (cpha) begin
              mosi     <= 1'b0;
              tx_shift <= tx_load;
            end else begin
              mosi     <= tx_load[DATA_W-1];
              tx_shift <= {tx_load[DATA_W-2:0], 1'b0};
            end
          end
        end
        SETUP: begin
          if (div_done) state <= XFER;
        end
        XFER: begin
          if (sclk_edge && (edge_num == EDGE_LAST)) state <= HOLD;
        end
        HOLD: begin
          if (div_done) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            rx_valid <= 1'b1;
            rx_data  <= rx_shift;
            cs_n     <= '1;
            mosi     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

  logic        clk;
  logic        rst;
  logic        tx_valid_c;
  logic [15:0] tx_data_c;
  logic [1:0]  cs_sel_c;
  logic        cpol_c, cpha_c, msb_c;
  logic        miso_c, miso_s, miso_loop;
  logic        use_big;

  logic        ready8, rx_valid8, busy8, sclk8, mosi8;
  logic [7:0]  rx_data8;
  logic [3:0]  cs_n8;
  logic        ready16, rx_valid16, busy16, sclk16, mosi16;
  logic [15:0] rx_data16;
  logic [0:0]  cs_n16;

  logic        ob_ready, ob_rx_valid, ob_busy, ob_sclk, ob_mosi;
  logic [15:0] ob_rx_data;
  logic [3:0]  ob_cs_n;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_ctr = 0;
  int last_rx_time = 0;
  int t_first;

  spi_master #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(4)) u_dut8 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_c & ~use_big), .tx_ready(ready8),
    .tx_data(tx_data_c[7:0]), .cs_sel(cs_sel_c), .cpol(cpol_c), .cpha(cpha_c),
    .msb_first(msb_c), .rx_valid(rx_valid8), .rx_data(rx_data8), .busy(busy8),
    .sclk(sclk8), .cs_n(cs_n8), .mosi(mosi8), .miso(miso_c)
  );

  spi_master #(.DATA_W(16), .CLK_DIV(2), .NUM_CS(1)) u_dut16 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_c & use_big), .tx_ready(ready16),
    .tx_data(tx_data_c), .cs_sel(cs_sel_c[0:0]), .cpol(cpol_c), .cpha(cpha_c),
    .msb_first(msb_c), .rx_valid(rx_valid16), .rx_data(rx_data16), .busy(busy16),
    .sclk(sclk16), .cs_n(cs_n16), .mosi(mosi16), .miso(miso_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  always_comb begin
    ob_ready    = use_big ? ready16    : ready8;
    ob_rx_valid = use_big ? rx_valid16 : rx_valid8;
    ob_busy     = use_big ? busy16     : busy8;
    ob_sclk     = use_big ? sclk16     : sclk8;
    ob_mosi     = use_big ? mosi16     : mosi8;
    ob_rx_data  = use_big ? rx_data16  : {8'h00, rx_data8};
    ob_cs_n     = use_big ? {3'b111, cs_n16} : cs_n8;
    miso_c      = miso_loop ? ob_mosi : miso_s;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge of the rx_valid cycle.
  task automatic run_xfer(input bit big, input logic [15:0] data, input logic [1:0] sel,
                          input bit pol, input bit pha, input bit msb, input bit loop,
                          input logic [15:0] slave_word, input logic [3:0] exp_cs,
                          input int exp_low, input logic [15:0] exp_seq,
                          input logic [15:0] exp_rx, input bit poke_busy);
    int dw, div, cyc, low, edges, first_e, last_e, gap_bad, viol, rx_cyc, sbit;
    logic prev_sclk, prev_mosi, lead, edge_now;
    logic [15:0] seq;
    dw = big ? 16 : 8;
    div = big ? 2 : 4;
    low = 0; edges = 0; first_e = 0; last_e = 0; gap_bad = 0; viol = 0;
    rx_cyc = 0; sbit = 0; seq = '0;
    use_big = big;
    check("tx_ready_idle", ob_ready, 1);
    tx_data_c = data; cs_sel_c = sel; cpol_c = pol; cpha_c = pha; msb_c = msb;
    miso_loop = loop; miso_s = 1'b0; tx_valid_c = 1'b1;
    @(negedge clk);
    tx_valid_c = 1'b0;
    cyc = 1;
    check("cs_n_fall", ob_cs_n, exp_cs);
    check("sclk_setup", ob_sclk, pol);
    prev_sclk = pol;
    prev_mosi = ob_mosi;
    while (rx_cyc == 0 && cyc < 200) begin
      if (ob_rx_valid) begin
        rx_cyc = cyc;
      end else begin
        if (ob_cs_n == exp_cs) low++;
        edge_now = (ob_sclk != prev_sclk);
        lead = (ob_sclk != pol);
        if (edge_now) begin
          edges++;
          if (edges == 1) first_e = cyc;
          else if (cyc - last_e != div) gap_bad++;
          last_e = cyc;
          if (lead != pha) seq = {seq[14:0], ob_mosi};
          if (!loop && pha && lead && sbit < dw) begin
            miso_s = slave_word[dw-1-sbit];
            sbit++;
          end
        end
        if (cyc > 1 && ob_mosi != prev_mosi && !(edge_now && (lead == pha))) viol++;
        prev_sclk = ob_sclk;
        prev_mosi = ob_mosi;
        if (poke_busy && cyc == 10) begin
          tx_data_c = ~data;
          tx_valid_c = 1'b1;
        end
        if (poke_busy && cyc == 11) tx_valid_c = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    last_rx_time = cyc_ctr;
    check("rx_cycle", rx_cyc, exp_low + 1);
    check("cs_low_cycles", low, exp_low);
    check("sclk_edges", edges, 2 * dw);
    check("first_edge", first_e, div + 1);
    check("edge_gaps", gap_bad, 0);
    check("mosi_seq", seq, exp_seq);
    check("mosi_change_edge", viol, 0);
    check("rx_data", ob_rx_data, exp_rx);
    check("cs_n_end", ob_cs_n, 4'hF);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tx_valid_c = 1'b0; tx_data_c = '0; cs_sel_c = '0;
    cpol_c = 1'b0; cpha_c = 1'b0; msb_c = 1'b1; miso_loop = 1'b1; miso_s = 1'b0;
    use_big = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", ob_ready, 1);
    check("rst_busy", ob_busy, 0);
    check("rst_rx_valid", ob_rx_valid, 0);
    check("rst_rx_data", ob_rx_data, 0);
    check("rst_cs_n", ob_cs_n, 4'hF);
    check("rst_sclk", ob_sclk, 0);
    check("rst_mosi", ob_mosi, 0);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0, MSB first, loopback
    run_xfer(1'b0, 16'h00A3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000,
             4'b1110, 68, 16'h00A3, 16'h00A3, 1'b0);
    // Mode 3, slave returns 8'h96
    run_xfer(1'b0, 16'h005C, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0096,
             4'b1101, 68, 16'h005C, 16'h0096, 1'b0);
    check("idle_sclk_mode3", ob_sclk, 1);
    // Back-to-back on cs 2 then cs 3
    run_xfer(1'b0, 16'h003C, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000,
             4'b1011, 68, 16'h003C, 16'h003C, 1'b0);
    t_first = last_rx_time;
    run_xfer(1'b0, 16'h00C5, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000,
             4'b0111, 68, 16'h00C5, 16'h00C5, 1'b0);
    check("b2b_rx_spacing", last_rx_time - t_first, 69);

    // Abort at cycle 30 of a transfer
    use_big = 1'b0; tx_data_c = 16'h00FF; cs_sel_c = 2'd0;
    cpol_c = 1'b0; cpha_c = 1'b0; msb_c = 1'b1; miso_loop = 1'b1; tx_valid_c = 1'b1;
    @(negedge clk);
    tx_valid_c = 1'b0;
    repeat (29) @(negedge clk);
    check("abort_mid_busy", ob_busy, 1);
    check("abort_mid_sclk", ob_sclk, 1);
    check("abort_mid_mosi", ob_mosi, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs_n", ob_cs_n, 4'hF);
    check("abort_sclk", ob_sclk, 0);
    check("abort_mosi", ob_mosi, 0);
    check("abort_ready", ob_ready, 1);
    check("abort_rx_data", ob_rx_data, 0);
    // Mode 1, LSB first, accepted straight after the abort; no stray rx_valid allowed
    run_xfer(1'b0, 16'h0001, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000,
             4'b1110, 68, 16'h0080, 16'h0001, 1'b0);

    // 16-bit, divider 2, with a request poked while busy
    run_xfer(1'b1, 16'hBEEF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000,
             4'b1110, 66, 16'hBEEF, 16'hBEEF, 1'b1);
    @(negedge clk);
    check("busy_after_poke", ob_busy, 0);
    check("rx_valid_one_cycle", ob_rx_valid, 0);
    // Out-of-range chip select: full timing, no cs_n asserted
    run_xfer(1'b1, 16'h1234, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000,
             4'b1111, 66, 16'h1234, 16'h1234, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
